// File: rtl/direction_input_resolver.sv
// Multi-axis push-button front end: per-button synchroniser and debouncer,
// then per-axis resolution of the negative/positive pair into a direction code.
module direction_input_resolver #(
    parameter int NUM_AXES        = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MODE            = 0
) (
    input  logic                  clock_100mhz,
    input  logic                  reset,
    input  logic                  game_active,
    input  logic [NUM_AXES-1:0]   btn_neg,
    input  logic [NUM_AXES-1:0]   btn_pos,
    output logic [2*NUM_AXES-1:0] dir_out,
    output logic [NUM_AXES-1:0]   dir_changed
);

    localparam int NUM_BTNS = 2 * NUM_AXES;

    typedef enum logic [1:0] {
        DIR_NULL = 2'b00,
        DIR_NEG  = 2'b01,
        DIR_POS  = 2'b10
    } dir_t;

    // Button vector layout: negative buttons low, positive buttons high.
    logic [NUM_BTNS-1:0] raw_btn;
    logic [NUM_BTNS-1:0] sync_meta;
    logic [NUM_BTNS-1:0] sync_out;
    logic [NUM_BTNS-1:0] deb_level;

    assign raw_btn = {btn_pos, btn_neg};

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clock_100mhz) begin
        if (reset) begin
            sync_meta <= '0;
            sync_out  <= '0;
        end else begin
            sync_meta <= raw_btn;
            sync_out  <= sync_meta;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign deb_level = sync_out;
        end else begin : g_debounce
            localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            for (genvar b = 0; b < NUM_BTNS; b++) begin : g_btn
                logic [CNT_W-1:0] stable_cnt;
                logic             level;

                // Counter only advances while synced and debounced levels disagree.
                always_ff @(posedge clock_100mhz) begin
                    if (reset) begin
                        stable_cnt <= '0;
                        level      <= 1'b0;
                    end else if (sync_out[b] == level) begin
                        stable_cnt <= '0;
                    end else if (stable_cnt == CNT_LAST) begin
                        level      <= sync_out[b];
                        stable_cnt <= '0;
                    end else begin
                        stable_cnt <= stable_cnt + CNT_W'(1);
                    end
                end

                assign deb_level[b] = level;
            end
        end
    endgenerate

    logic [NUM_AXES-1:0]   hist_neg;
    logic [NUM_AXES-1:0]   hist_pos;
    logic                  active_q;
    logic [2*NUM_AXES-1:0] dir_next;
    logic [NUM_AXES-1:0]   dir_diff;
    logic [NUM_AXES-1:0]   change_q;

    function automatic dir_t resolve(input logic n, input logic p,
                                     input logic n_prev, input logic p_prev,
                                     input dir_t held);
        dir_t r;
        r = DIR_NULL;
        unique case ({n, p})
            2'b10: r = DIR_NEG;
            2'b01: r = DIR_POS;
            2'b11: begin
                if (MODE == 0) begin
                    unique case ({n_prev, p_prev})
                        2'b10:   r = DIR_POS;
                        2'b01:   r = DIR_NEG;
                        2'b11:   r = held;
                        default: r = DIR_NULL;
                    endcase
                end
            end
            default: r = DIR_NULL;
        endcase
        return r;
    endfunction

    // NOTE: defaults first so the combinational outputs never infer latches.
    always_comb begin
        dir_next = '0;
        dir_diff = '0;
        for (int a = 0; a < NUM_AXES; a++) begin
            // History is masked on the first active cycle so held buttons re-resolve.
            if (game_active) begin
                dir_next[2*a +: 2] = resolve(deb_level[a], deb_level[NUM_AXES + a],
                                             active_q & hist_neg[a],
                                             active_q & hist_pos[a],
                                             dir_t'(dir_out[2*a +: 2]));
            end
            dir_diff[a] = (dir_next[2*a +: 2] != dir_out[2*a +: 2]);
        end
    end

    always_ff @(posedge clock_100mhz) begin
        if (reset) begin
            dir_out     <= '0;
            dir_changed <= '0;
            change_q    <= '0;
            hist_neg    <= '0;
            hist_pos    <= '0;
            active_q    <= 1'b0;
        end else begin
            dir_out     <= dir_next;
            change_q    <= dir_diff;
            dir_changed <= change_q;
            hist_neg    <= deb_level[NUM_AXES-1:0];
            hist_pos    <= deb_level[NUM_BTNS-1:NUM_AXES];
            active_q    <= game_active;
        end
    end

endmodule

// File: tb/tb_direction_input_resolver.sv
// Bench for direction_input_resolver: three configurations against a rule-level
// model compared every cycle, plus hand-computed checkpoints.
module tb_direction_input_resolver;

    logic clock_100mhz = 1'b0;
    always #5 clock_100mhz = ~clock_100mhz;

    logic       reset;
    logic       game_active;
    logic [1:0] neg_a, pos_a, neg_b, pos_b;
    logic [3:0] neg_c, pos_c;
    logic [3:0] dir_a, dir_b;
    logic [1:0] chg_a, chg_b;
    logic [7:0] dir_c;
    logic [3:0] chg_c;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    direction_input_resolver #(.NUM_AXES(2), .DEBOUNCE_CYCLES(4), .MODE(0)) u_a (
        .clock_100mhz(clock_100mhz), .reset(reset), .game_active(game_active),
        .btn_neg(neg_a), .btn_pos(pos_a), .dir_out(dir_a), .dir_changed(chg_a));

    direction_input_resolver #(.NUM_AXES(2), .DEBOUNCE_CYCLES(4), .MODE(1)) u_b (
        .clock_100mhz(clock_100mhz), .reset(reset), .game_active(game_active),
        .btn_neg(neg_b), .btn_pos(pos_b), .dir_out(dir_b), .dir_changed(chg_b));

    direction_input_resolver #(.NUM_AXES(4), .DEBOUNCE_CYCLES(0), .MODE(0)) u_c (
        .clock_100mhz(clock_100mhz), .reset(reset), .game_active(game_active),
        .btn_neg(neg_c), .btn_pos(pos_c), .dir_out(dir_c), .dir_changed(chg_c));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock_100mhz);
    endtask

    // ---------------- model ----------------
    localparam int NI = 3;
    int m_d    [NI] = '{4, 4, 0};
    int m_mode [NI] = '{0, 1, 0};
    int m_na   [NI] = '{2, 2, 4};

    // Per instance, button b: bits[3:0] negative axes, bits[7:4] positive axes.
    logic [7:0] m_s1   [NI];
    logic [7:0] m_s2   [NI];
    logic [7:0] m_deb  [NI];
    logic [7:0] m_hist [NI];
    logic [7:0] m_win  [NI*8];
    logic [7:0] m_dir  [NI];
    logic [3:0] m_c1   [NI];
    logic [3:0] m_c2   [NI];
    logic       m_gaq;

    function automatic logic [7:0] raw_of(input int k);
        case (k)
            0:       return {2'b00, pos_a, 2'b00, neg_a};
            1:       return {2'b00, pos_b, 2'b00, neg_b};
            default: return {pos_c, neg_c};
        endcase
    endfunction

    // True when the newest d synced samples all equal v.
    function automatic bit settled(input logic [7:0] w, input int d, input logic v);
        for (int i = 0; i < d; i++) if (w[i] !== v) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [1:0] rule(input logic n, input logic p, input logic pn,
                                        input logic pp, input logic [1:0] cur, input int mode);
        if (n == p && n == 1'b0) return 2'b00;
        if (n && !p)             return 2'b01;
        if (!n && p)             return 2'b10;
        if (mode == 1)           return 2'b00;
        if (pn && !pp)           return 2'b10;
        if (!pn && pp)           return 2'b01;
        if (pn && pp)            return cur;
        return 2'b00;
    endfunction

    always @(posedge clock_100mhz) begin : model
        logic [7:0] raw, deb_cur, deb_nx, w, dnx;
        logic [3:0] diff;
        for (int k = 0; k < NI; k++) begin
            raw = raw_of(k);
            if (reset) begin
                m_s1[k] <= '0; m_s2[k] <= '0; m_deb[k] <= '0; m_hist[k] <= '0;
                m_dir[k] <= '0; m_c1[k] <= '0; m_c2[k] <= '0;
                for (int b = 0; b < 8; b++) m_win[k*8 + b] <= '0;
            end else begin
                deb_cur = (m_d[k] == 0) ? m_s2[k] : m_deb[k];
                deb_nx  = m_deb[k];
                for (int b = 0; b < 8; b++) begin
                    w = {m_win[k*8 + b][6:0], m_s2[k][b]};
                    m_win[k*8 + b] <= w;
                    if (m_d[k] > 0 && settled(w, m_d[k], ~m_deb[k][b]))
                        deb_nx[b] = ~m_deb[k][b];
                end
                dnx  = '0;
                diff = '0;
                for (int a = 0; a < m_na[k]; a++) begin
                    if (game_active)
                        dnx[2*a +: 2] = rule(deb_cur[a], deb_cur[4+a],
                                             m_gaq & m_hist[k][a], m_gaq & m_hist[k][4+a],
                                             m_dir[k][2*a +: 2], m_mode[k]);
                    diff[a] = (dnx[2*a +: 2] != m_dir[k][2*a +: 2]);
                end
                m_dir[k]  <= dnx;
                m_c1[k]   <= diff;
                m_c2[k]   <= m_c1[k];
                m_hist[k] <= deb_cur;
                m_deb[k]  <= deb_nx;
                m_s2[k]   <= m_s1[k];
                m_s1[k]   <= raw;
            end
        end
        m_gaq <= reset ? 1'b0 : game_active;
    end

    always @(negedge clock_100mhz) begin
        if (cmp_en) begin
            check("cmp_dir_a", dir_a, m_dir[0][3:0]);
            check("cmp_chg_a", chg_a, m_c2[0][1:0]);
            check("cmp_dir_b", dir_b, m_dir[1][3:0]);
            check("cmp_chg_b", chg_b, m_c2[1][1:0]);
            check("cmp_dir_c", dir_c, m_dir[2]);
            check("cmp_chg_c", chg_c, m_c2[2]);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; game_active = 1'b1;
        neg_a = '0; pos_a = '0; neg_b = '0; pos_b = '0; neg_c = '0; pos_c = '0;
        tick(2);
        check("reset_dir_a", dir_a, 4'h0);
        check("reset_chg_a", chg_a, 2'b00);
        check("reset_dir_c", dir_c, 8'h00);
        cmp_en = 1'b1;
        reset  = 1'b0;
        tick(2);

        // T1: press and release with D+3 latency, one-cycle-late change pulse
        neg_a[0] = 1'b1;
        tick(6); check("t1_early", dir_a, 4'b0000);
        tick(1); check("t1_neg", dir_a, 4'b0001);
                 check("t1_no_pulse_yet", chg_a, 2'b00);
        tick(1); check("t1_pulse", chg_a, 2'b01);
        tick(1); check("t1_pulse_end", chg_a, 2'b00);
        neg_a[0] = 1'b0;
        tick(7); check("t1_release", dir_a, 4'b0000);
        tick(1); check("t1_release_pulse", chg_a, 2'b01);
        tick(4);

        // T2: 3-cycle glitch rejected, 4-cycle pulse accepted
        pos_a[1] = 1'b1; tick(3); pos_a[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("t2_glitch_dir", dir_a, 4'b0000);
            check("t2_glitch_chg", chg_a, 2'b00);
        end
        pos_a[1] = 1'b1; tick(4); pos_a[1] = 1'b0;
        tick(3); check("t2_pulse_pos", dir_a, 4'b1000);
        tick(10);

        // T3: last-pressed wins
        neg_a[0] = 1'b1; tick(7); check("t3_neg", dir_a, 4'b0001);
        pos_a[0] = 1'b1; tick(7); check("t3_pos_wins", dir_a, 4'b0010);
        tick(3);         check("t3_hold", dir_a, 4'b0010);
        pos_a[0] = 1'b0; tick(7); check("t3_back_neg", dir_a, 4'b0001);
        neg_a[0] = 1'b0; tick(7); check("t3_idle", dir_a, 4'b0000);
        tick(3);
        neg_a[0] = 1'b1; pos_a[0] = 1'b1;
        tick(7); check("t3_simul", dir_a, 4'b0000);
        tick(5); check("t3_simul_hold", dir_a, 4'b0000);
        neg_a[0] = 1'b0; pos_a[0] = 1'b0;

        // T4: cancel mode
        neg_b[0] = 1'b1; pos_b[0] = 1'b1;
        tick(9); check("t4_both_null", dir_b, 4'b0000);
        neg_b[0] = 1'b0;
        tick(6); check("t4_early", dir_b, 4'b0000);
        tick(1); check("t4_pos", dir_b, 4'b0010);
        neg_b[0] = 1'b1;
        tick(7); check("t4_cancel", dir_b, 4'b0000);
        neg_b[0] = 1'b0; pos_b[0] = 1'b0;
        tick(10);

        // T5: game_active gating
        neg_a[0] = 1'b1; tick(8); check("t5_neg", dir_a, 4'b0001);
        game_active = 1'b0;
        tick(1); check("t5_gate_off", dir_a, 4'b0000);
        tick(1); check("t5_gate_pulse", chg_a, 2'b01);
        game_active = 1'b1;
        tick(1); check("t5_gate_on", dir_a, 4'b0001);
        game_active = 1'b0; pos_a[0] = 1'b1;
        tick(10);
        game_active = 1'b1;
        tick(1); check("t5_both_on", dir_a, 4'b0000);
        tick(3); check("t5_both_hold", dir_a, 4'b0000);
        neg_a[0] = 1'b0;
        tick(7); check("t5_release_neg", dir_a, 4'b0010);
        pos_a[0] = 1'b0;
        tick(10);

        // T6: reset while held (D=0 instance) and mid-debounce (D=4 instance)
        neg_c = 4'hF; neg_a[1] = 1'b1;
        tick(5); check("t6_held", dir_c, 8'h55);
        reset = 1'b1;
        tick(1); check("t6_reset_dir", dir_c, 8'h00);
                 check("t6_reset_chg", chg_c, 4'h0);
        tick(2); check("t6_reset_dir_a", dir_a, 4'h0);
        reset = 1'b0;
        tick(2); check("t6_pre_entry", dir_c, 8'h00);
        tick(1); check("t6_reentry", dir_c, 8'h55);
        tick(1); check("t6_reentry_pulse", chg_c, 4'hF);
        tick(2); check("t6_a_early", dir_a, 4'b0000);
        tick(1); check("t6_a_reentry", dir_a, 4'b0100);
        pos_c[2] = 1'b1;
        tick(3); check("t6_axis2_pos", dir_c, 8'h65);
        neg_c[0] = 1'b0; pos_c[1] = 1'b1;
        tick(3); check("t6_two_axes", dir_c, 8'h68);
        tick(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
